// File: rtl/stream_source_pkg.sv
// Network-side sizing and source-side configuration shared by the stream source,
// its interface and the test bench.
package network_config;
   localparam int NET_NUM_INP = 4;
endpackage

package source_config;
   import network_config::*;

   localparam int SRC_OPC_WIDTH   = 0;
   localparam int SRC_SPK_WIDTH   = NET_NUM_INP;
   localparam int SRC_RUN_DEFAULT = 8;
   localparam int SRC_WIDTH       = SRC_SPK_WIDTH + SRC_RUN_DEFAULT;

   typedef enum logic [1:0] {IDLE, SPIKE, RUN} src_state_t;

   // Host spike field is MSB-first; network input 0 takes the top bit.
   function automatic logic [SRC_SPK_WIDTH-1:0] map_spikes(input logic [SRC_SPK_WIDTH-1:0] spk);
      logic [SRC_SPK_WIDTH-1:0] res;
      for (int i = 0; i < SRC_SPK_WIDTH; i++) begin
         res[i] = spk[SRC_SPK_WIDTH-1-i];
      end
      return res;
   endfunction
endpackage

// File: rtl/stream_source_if.sv
// Host-word input and network-cycle output handshakes of the stream source.
interface stream_source_if #(
   parameter int SPK_W = source_config::SRC_SPK_WIDTH,
   parameter int RUN_W = source_config::SRC_RUN_DEFAULT
);
   logic                   src_valid;
   logic                   src_ready;
   logic [SPK_W+RUN_W-1:0] src;
   logic                   net_ready;
   logic                   net_valid;
   logic                   net_last;
   logic [SPK_W-1:0]       net_inp;

   modport master (
      input  src_valid, src, net_ready,
      output src_ready, net_valid, net_last, net_inp
   );

   modport slave (
      output src_valid, src, net_ready,
      input  src_ready, net_valid, net_last, net_inp
   );
endinterface

// File: rtl/stream_skid_buffer.sv
// Two-entry registered FIFO; in_ready is a flop so it never depends on out_ready
// within the same cycle.
module stream_skid_buffer #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
);
   logic [DATA_W-1:0] mem [2];
   logic              wr_ptr;
   logic              rd_ptr;
   logic [1:0]        count;
   logic [1:0]        count_nxt;
   logic              ready_q;
   logic              push;
   logic              pop;

   assign push      = in_valid && ready_q;
   assign pop       = out_valid && out_ready;
   assign out_valid = (count != 2'd0);
   assign out_data  = mem[rd_ptr];
   assign in_ready  = ready_q;

   always_comb begin
      count_nxt = count;
      case ({push, pop})
         2'b10:   count_nxt = count + 2'd1;
         2'b01:   count_nxt = count - 2'd1;
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count   <= 2'd0;
         wr_ptr  <= 1'b0;
         rd_ptr  <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         count   <= count_nxt;
         ready_q <= (count_nxt != 2'd2);
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
   end
endmodule

// File: rtl/stream_source.sv
// Host-to-network stream source: each word yields one spike cycle followed by
// `run` idle cycles, with net_last on the final cycle.
//
//   state | meaning
//   IDLE  | nothing on the network; pop the next buffered word when present
//   SPIKE | driving the word's spikes; net_last when run is zero
//   RUN   | driving zero spikes; counter holds remaining idle cycles
module stream_source
   import source_config::*;
#(
   parameter int SRC_RUN_WIDTH = 8
) (
   input  logic            clk,
   input  logic            rst,
   stream_source_if.master bus
);
   localparam int WORD_W = SRC_SPK_WIDTH + SRC_RUN_WIDTH;

   src_state_t               state;
   src_state_t               state_nxt;
   logic [SRC_RUN_WIDTH-1:0] cnt;
   logic [SRC_RUN_WIDTH-1:0] cnt_nxt;
   logic [SRC_SPK_WIDTH-1:0] spk_q;
   logic [SRC_SPK_WIDTH-1:0] spk_nxt;

   logic [WORD_W-1:0]        head;
   logic                     head_valid;
   logic                     head_ready;
   logic                     net_valid;
   logic                     net_last;
   logic [SRC_SPK_WIDTH-1:0] net_inp;
   logic                     net_accept;

   stream_skid_buffer #(
      .DATA_W(WORD_W)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (bus.src_valid),
      .in_ready  (bus.src_ready),
      .in_data   (bus.src),
      .out_valid (head_valid),
      .out_ready (head_ready),
      .out_data  (head)
   );

   assign net_accept    = net_valid && bus.net_ready;
   assign bus.net_valid = net_valid;
   assign bus.net_last  = net_last;
   assign bus.net_inp   = net_inp;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         spk_q <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         spk_q <= spk_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      spk_nxt    = spk_q;
      head_ready = 1'b0;
      net_valid  = 1'b0;
      net_last   = 1'b0;
      net_inp    = '0;

      case (state)
         IDLE: begin
            head_ready = 1'b1;
         end
         SPIKE: begin
            net_valid = 1'b1;
            net_inp   = spk_q;
            net_last  = (cnt == '0);
            if (net_accept) begin
               if (net_last) begin
                  head_ready = 1'b1;
                  state_nxt  = IDLE;
               end else begin
                  state_nxt  = RUN;
               end
            end
         end
         RUN: begin
            net_valid = 1'b1;
            net_last  = (cnt == SRC_RUN_WIDTH'(1));
            if (net_accept) begin
               if (net_last) begin
                  head_ready = 1'b1;
                  state_nxt  = IDLE;
               end else begin
                  cnt_nxt    = cnt - 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase

      // Popping at a word's final accept gives back-to-back words with no bubble.
      if (head_ready && head_valid) begin
         state_nxt = SPIKE;
         cnt_nxt   = head[SRC_RUN_WIDTH-1:0];
         spk_nxt   = map_spikes(head[WORD_W-1:SRC_RUN_WIDTH]);
      end
   end
endmodule

// File: tb/tb_stream_source.sv
// Directed self-checking bench for stream_source with immediate assertions.
module tb_stream_source;
   import source_config::*;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   stream_source_if bus ();

   stream_source dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for net_valid, checks the beat, then lets it be accepted.
   task automatic expect_beat(input string tag, input logic [3:0] exp_inp, input logic exp_last);
      int n;
      n = 0;
      while (!bus.net_valid && n < 8) begin
         tick();
         n++;
      end
      check({tag, "_valid"}, 32'(bus.net_valid), 32'd1);
      check({tag, "_inp"},   32'(bus.net_inp),   32'(exp_inp));
      check({tag, "_last"},  32'(bus.net_last),  32'(exp_last));
      tick();
   endtask

   initial begin
      int         beats;
      int         lasts;
      int         last_idx;
      logic [3:0] first_inp;

      rst           = 1'b1;
      bus.src_valid = 1'b0;
      bus.src       = '0;
      bus.net_ready = 1'b0;
      tick();
      tick();
      check("rst_src_ready", 32'(bus.src_ready), 32'd0);
      check("rst_net_valid", 32'(bus.net_valid), 32'd0);
      check("rst_net_last",  32'(bus.net_last),  32'd0);
      check("rst_net_inp",   32'(bus.net_inp),   32'd0);
      rst = 1'b0;
      tick();
      check("post_rst_src_ready", 32'(bus.src_ready), 32'd1);

      // run=0 word: net_valid exactly two edges after the accept, one cycle long
      bus.net_ready = 1'b1;
      bus.src_valid = 1'b1;
      bus.src       = {4'b1000, 8'd0};
      tick();
      bus.src_valid = 1'b0;
      check("w0_lat1_valid", 32'(bus.net_valid), 32'd0);
      tick();
      check("w0_valid", 32'(bus.net_valid), 32'd1);
      check("w0_inp",   32'(bus.net_inp),   32'h1);
      check("w0_last",  32'(bus.net_last),  32'd1);
      tick();
      check("w0_done_valid", 32'(bus.net_valid), 32'd0);

      // run=3 word
      bus.src_valid = 1'b1;
      bus.src       = {4'b1010, 8'd3};
      tick();
      bus.src_valid = 1'b0;
      expect_beat("w1_b0", 4'b0101, 1'b0);
      expect_beat("w1_b1", 4'b0000, 1'b0);
      expect_beat("w1_b2", 4'b0000, 1'b0);
      expect_beat("w1_b3", 4'b0000, 1'b1);
      check("w1_done_valid", 32'(bus.net_valid), 32'd0);

      // Three words while the network stalls, so the buffer fills
      bus.net_ready = 1'b0;
      bus.src_valid = 1'b1;
      bus.src       = {4'b0001, 8'd0};
      tick();
      bus.src       = {4'b0010, 8'd1};
      tick();
      bus.src       = {4'b0100, 8'd0};
      tick();
      bus.src_valid = 1'b0;
      check("b2b_full_ready", 32'(bus.src_ready), 32'd0);
      check("b2b_stall_inp",  32'(bus.net_inp),   32'h8);
      tick();
      check("b2b_hold_ready", 32'(bus.src_ready), 32'd0);
      check("b2b_hold_valid", 32'(bus.net_valid), 32'd1);
      check("b2b_hold_inp",   32'(bus.net_inp),   32'h8);
      check("b2b_hold_last",  32'(bus.net_last),  32'd1);
      bus.net_ready = 1'b1;
      check("b2b_c0_valid", 32'(bus.net_valid), 32'd1);
      check("b2b_c0_inp",   32'(bus.net_inp),   32'h8);
      check("b2b_c0_last",  32'(bus.net_last),  32'd1);
      tick();
      check("b2b_freed_ready", 32'(bus.src_ready), 32'd1);
      check("b2b_c1_valid", 32'(bus.net_valid), 32'd1);
      check("b2b_c1_inp",   32'(bus.net_inp),   32'h4);
      check("b2b_c1_last",  32'(bus.net_last),  32'd0);
      tick();
      check("b2b_c2_valid", 32'(bus.net_valid), 32'd1);
      check("b2b_c2_inp",   32'(bus.net_inp),   32'h0);
      check("b2b_c2_last",  32'(bus.net_last),  32'd1);
      tick();
      check("b2b_c3_valid", 32'(bus.net_valid), 32'd1);
      check("b2b_c3_inp",   32'(bus.net_inp),   32'h2);
      check("b2b_c3_last",  32'(bus.net_last),  32'd1);
      tick();
      check("b2b_done_valid", 32'(bus.net_valid), 32'd0);

      // run=2 word with net_ready 1,0,0,1 during the idle cycles
      bus.src_valid = 1'b1;
      bus.src       = {4'b0110, 8'd2};
      tick();
      bus.src_valid = 1'b0;
      tick();
      check("stl_b0_inp",  32'(bus.net_inp),  32'h6);
      check("stl_b0_last", 32'(bus.net_last), 32'd0);
      tick();
      bus.net_ready = 1'b0;
      check("stl_b1_valid", 32'(bus.net_valid), 32'd1);
      check("stl_b1_inp",   32'(bus.net_inp),   32'h0);
      check("stl_b1_last",  32'(bus.net_last),  32'd0);
      tick();
      check("stl_h1_valid", 32'(bus.net_valid), 32'd1);
      check("stl_h1_last",  32'(bus.net_last),  32'd0);
      tick();
      check("stl_h2_valid", 32'(bus.net_valid), 32'd1);
      check("stl_h2_last",  32'(bus.net_last),  32'd0);
      bus.net_ready = 1'b1;
      tick();
      check("stl_b2_valid", 32'(bus.net_valid), 32'd1);
      check("stl_b2_inp",   32'(bus.net_inp),   32'h0);
      check("stl_b2_last",  32'(bus.net_last),  32'd1);
      tick();
      check("stl_done_valid", 32'(bus.net_valid), 32'd0);

      // Maximum run: 256 beats, one net_last at the very end
      bus.src_valid = 1'b1;
      bus.src       = {4'b0001, 8'd255};
      tick();
      bus.src_valid = 1'b0;
      beats     = 0;
      lasts     = 0;
      last_idx  = -1;
      first_inp = 4'b0;
      for (int i = 0; i < 400; i++) begin
         if (bus.net_valid) begin
            if (beats == 0) first_inp = bus.net_inp;
            if (bus.net_last) begin
               lasts++;
               last_idx = beats;
            end
            beats++;
         end else if (beats > 0) begin
            break;
         end
         tick();
      end
      check("max_beats",    32'(beats),     32'd256);
      check("max_lasts",    32'(lasts),     32'd1);
      check("max_last_idx", 32'(last_idx),  32'd255);
      check("max_first",    32'(first_inp), 32'h8);

      // Reset in the 2nd RUN cycle of a run=5 word with another word buffered
      bus.src_valid = 1'b1;
      bus.src       = {4'b1111, 8'd5};
      tick();
      bus.src       = {4'b0011, 8'd0};
      tick();
      bus.src_valid = 1'b0;
      check("mr_spike_inp", 32'(bus.net_inp), 32'hF);
      tick();
      tick();
      check("mr_run2_valid", 32'(bus.net_valid), 32'd1);
      check("mr_run2_last",  32'(bus.net_last),  32'd0);
      rst = 1'b1;
      tick();
      check("mr_rst_valid", 32'(bus.net_valid), 32'd0);
      check("mr_rst_last",  32'(bus.net_last),  32'd0);
      check("mr_rst_inp",   32'(bus.net_inp),   32'd0);
      check("mr_rst_ready", 32'(bus.src_ready), 32'd0);
      rst = 1'b0;
      tick();
      check("mr_post_ready", 32'(bus.src_ready), 32'd1);
      check("mr_post_valid", 32'(bus.net_valid), 32'd0);
      tick();
      check("mr_discard_valid", 32'(bus.net_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
